// File: rtl/systolic_pe_mac.sv
// Systolic-array PE: forwards A/B to the east/south neighbours, multiplies coincident
// operands and accumulates a programmable number of products into one saturated result.

module systolic_pe_fwd #(
  parameter int DW = 16
) (
  input  logic          CLK,
  input  logic          RSTN,
  input  logic [DW-1:0] d,
  input  logic          v,
  output logic [DW-1:0] q,
  output logic          qv
);
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      q  <= '0;
      qv <= 1'b0;
    end else begin
      qv <= v;
      if (v) q <= d;
    end
  end
endmodule

module systolic_pe_mac #(
  parameter int DW = 16,
  parameter int AW = 40,
  parameter int LW = 8
) (
  input  logic          CLK,
  input  logic          RSTN,
  input  logic          CLR,
  input  logic [LW-1:0] CFG_LEN,
  input  logic          CFG_SIGNED,
  input  logic [DW-1:0] DATA_A,
  input  logic          VALID_A,
  input  logic [DW-1:0] DATA_B,
  input  logic          VALID_B,
  output logic [DW-1:0] NEXT_DATA_A,
  output logic          NEXT_VALID_A,
  output logic [DW-1:0] NEXT_DATA_B,
  output logic          NEXT_VALID_B,
  output logic [AW-1:0] OUT_DATA,
  output logic          OUT_SAT,
  output logic          OUT_VALID,
  input  logic          OUT_READY,
  output logic          BUSY,
  output logic          OVERRUN
);

  logic [1:0][DW-1:0] fwd_d, fwd_q;
  logic [1:0]         fwd_v, fwd_qv;

  assign fwd_d = {DATA_B, DATA_A};
  assign fwd_v = {VALID_B, VALID_A};

  for (genvar i = 0; i < 2; i++) begin : g_fwd
    systolic_pe_fwd #(.DW(DW)) u_fwd (
      .CLK (CLK),
      .RSTN(RSTN),
      .d   (fwd_d[i]),
      .v   (fwd_v[i]),
      .q   (fwd_q[i]),
      .qv  (fwd_qv[i])
    );
  end

  assign NEXT_DATA_A  = fwd_q[0];
  assign NEXT_VALID_A = fwd_qv[0];
  assign NEXT_DATA_B  = fwd_q[1];
  assign NEXT_VALID_B = fwd_qv[1];

  logic            fire, busy, prod_v, bat_sat, ovf, batch_end, out_load;
  logic            sh_sgn, eff_sgn;
  logic [LW-1:0]   sh_len, eff_len, len_m1, cnt;
  logic [2*DW-1:0] a_x, b_x, prod_nx, prod;
  logic [AW-1:0]   acc, ext, sum_sat;
  logic [AW:0]     sum;

  assign fire    = VALID_A & VALID_B;
  assign busy    = (cnt != '0) | prod_v;
  assign BUSY    = busy;
  // Config is frozen in the shadow while anything of the batch is in flight.
  assign eff_len = busy ? sh_len : CFG_LEN;
  assign eff_sgn = busy ? sh_sgn : CFG_SIGNED;
  assign len_m1  = (eff_len == '0) ? '0 : eff_len - 1'b1;

  // One 2DW multiplier serves both modes: the low 2DW bits of the extended
  // operands' product are correct for signed and unsigned alike.
  assign a_x     = {{DW{eff_sgn & DATA_A[DW-1]}}, DATA_A};
  assign b_x     = {{DW{eff_sgn & DATA_B[DW-1]}}, DATA_B};
  assign prod_nx = a_x * b_x;

  always_comb begin
    ext = '0;
    ext[2*DW-1:0] = prod;
    for (int i = 2*DW; i < AW; i++) ext[i] = eff_sgn & prod[2*DW-1];
  end

  assign sum = {eff_sgn & acc[AW-1], acc} + {eff_sgn & ext[AW-1], ext};

  always_comb begin
    sum_sat = sum[AW-1:0];
    ovf     = 1'b0;
    if (eff_sgn) begin
      if (sum[AW] != sum[AW-1]) begin
        ovf     = 1'b1;
        sum_sat = sum[AW] ? {1'b1, {(AW-1){1'b0}}} : {1'b0, {(AW-1){1'b1}}};
      end
    end else if (sum[AW]) begin
      ovf     = 1'b1;
      sum_sat = '1;
    end
  end

  assign batch_end = prod_v & (cnt == len_m1);
  assign out_load  = batch_end & (~OUT_VALID | OUT_READY);

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      sh_len <= '0;
      sh_sgn <= 1'b0;
    end else if (!busy) begin
      sh_len <= CFG_LEN;
      sh_sgn <= CFG_SIGNED;
    end
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      prod    <= '0;
      prod_v  <= 1'b0;
      acc     <= '0;
      cnt     <= '0;
      bat_sat <= 1'b0;
    end else if (CLR) begin
      prod_v  <= 1'b0;
      acc     <= '0;
      cnt     <= '0;
      bat_sat <= 1'b0;
    end else begin
      prod_v <= fire;
      if (fire) prod <= prod_nx;
      if (prod_v) begin
        if (batch_end) begin
          acc     <= '0;
          cnt     <= '0;
          bat_sat <= 1'b0;
        end else begin
          acc     <= sum_sat;
          cnt     <= cnt + 1'b1;
          bat_sat <= bat_sat | ovf;
        end
      end
    end
  end

  // A full register with no accept at batch end drops the new result.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      OUT_DATA  <= '0;
      OUT_SAT   <= 1'b0;
      OUT_VALID <= 1'b0;
      OVERRUN   <= 1'b0;
    end else if (CLR) begin
      OUT_VALID <= 1'b0;
      OVERRUN   <= 1'b0;
    end else if (out_load) begin
      OUT_DATA  <= sum_sat;
      OUT_SAT   <= bat_sat | ovf;
      OUT_VALID <= 1'b1;
    end else begin
      if (batch_end) OVERRUN <= 1'b1;
      if (OUT_VALID & OUT_READY) OUT_VALID <= 1'b0;
    end
  end

endmodule

// File: tb/tb_systolic_pe_mac.sv
// Bench for systolic_pe_mac: a 40-bit and a 32-bit accumulator instance share stimulus
// and are compared every cycle against an integer-arithmetic model of the PE.

module tb_systolic_pe_mac;
  localparam int DW = 16;
  localparam int LW = 8;

  logic          clk = 1'b0, rstn = 1'b0, clr = 1'b0, cfg_signed = 1'b0;
  logic          va = 1'b0, vb = 1'b0, out_ready = 1'b0;
  logic [LW-1:0] cfg_len = '0;
  logic [DW-1:0] da = '0, db = '0;

  logic [DW-1:0] nda[2], ndb[2];
  logic          nva[2], nvb[2], ovld[2], osat[2], busy[2], ovr[2];
  logic [39:0]   od40;
  logic [31:0]   od32;

  always #5 clk = ~clk;

  systolic_pe_mac #(.DW(DW), .AW(40), .LW(LW)) u_dut40 (
    .CLK(clk), .RSTN(rstn), .CLR(clr), .CFG_LEN(cfg_len), .CFG_SIGNED(cfg_signed),
    .DATA_A(da), .VALID_A(va), .DATA_B(db), .VALID_B(vb),
    .NEXT_DATA_A(nda[0]), .NEXT_VALID_A(nva[0]), .NEXT_DATA_B(ndb[0]), .NEXT_VALID_B(nvb[0]),
    .OUT_DATA(od40), .OUT_SAT(osat[0]), .OUT_VALID(ovld[0]), .OUT_READY(out_ready),
    .BUSY(busy[0]), .OVERRUN(ovr[0])
  );

  systolic_pe_mac #(.DW(DW), .AW(32), .LW(LW)) u_dut32 (
    .CLK(clk), .RSTN(rstn), .CLR(clr), .CFG_LEN(cfg_len), .CFG_SIGNED(cfg_signed),
    .DATA_A(da), .VALID_A(va), .DATA_B(db), .VALID_B(vb),
    .NEXT_DATA_A(nda[1]), .NEXT_VALID_A(nva[1]), .NEXT_DATA_B(ndb[1]), .NEXT_VALID_B(nvb[1]),
    .OUT_DATA(od32), .OUT_SAT(osat[1]), .OUT_VALID(ovld[1]), .OUT_READY(out_ready),
    .BUSY(busy[1]), .OVERRUN(ovr[1])
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h want=%0h", tag, obs, exp);
    end
  endtask

  // Reference state: real integers, batch contents as plain sums.
  logic [DW-1:0] m_nda, m_ndb;
  bit            m_nva, m_nvb;
  bit            m_pv[2], m_sat[2], m_osat[2], m_ovld[2], m_ov[2], m_shs[2];
  longint        m_prod[2], m_acc[2], m_od[2];
  int            m_cnt[2], m_shl[2];

  function automatic longint sx(input logic [15:0] v, input bit s);
    if (s && v[15]) return longint'(v) - 65536;
    return longint'(v);
  endfunction

  task automatic model_reset();
    m_nda = '0; m_ndb = '0; m_nva = 0; m_nvb = 0;
    for (int k = 0; k < 2; k++) begin
      m_pv[k] = 0; m_sat[k] = 0; m_osat[k] = 0; m_ovld[k] = 0; m_ov[k] = 0; m_shs[k] = 0;
      m_prod[k] = 0; m_acc[k] = 0; m_od[k] = 0; m_cnt[k] = 0; m_shl[k] = 0;
    end
  endtask

  task automatic model_step();
    for (int k = 0; k < 2; k++) begin
      int     aw, len;
      bit     bsy, sg, cl, loaded;
      longint s, lo, hi;
      aw  = (k == 0) ? 40 : 32;
      bsy = (m_cnt[k] != 0) || m_pv[k];
      sg  = bsy ? m_shs[k] : cfg_signed;
      len = bsy ? m_shl[k] : int'(cfg_len);
      if (len == 0) len = 1;
      if (!bsy) begin m_shl[k] = int'(cfg_len); m_shs[k] = cfg_signed; end
      if (clr) begin
        m_pv[k] = 0; m_acc[k] = 0; m_cnt[k] = 0; m_sat[k] = 0; m_ovld[k] = 0; m_ov[k] = 0;
      end else begin
        loaded = 0;
        if (m_pv[k]) begin
          s  = m_acc[k] + m_prod[k];
          hi = sg ? (longint'(1) << (aw - 1)) - 1 : (longint'(1) << aw) - 1;
          lo = sg ? -(longint'(1) << (aw - 1)) : 0;
          cl = 0;
          if (s > hi) begin s = hi; cl = 1; end
          if (s < lo) begin s = lo; cl = 1; end
          if (m_cnt[k] + 1 == len) begin
            if (!m_ovld[k] || out_ready) begin
              m_od[k] = s; m_osat[k] = m_sat[k] | cl; m_ovld[k] = 1; loaded = 1;
            end else m_ov[k] = 1;
            m_acc[k] = 0; m_cnt[k] = 0; m_sat[k] = 0;
          end else begin
            m_acc[k] = s; m_cnt[k]++; m_sat[k] = m_sat[k] | cl;
          end
        end
        if (!loaded && m_ovld[k] && out_ready) m_ovld[k] = 0;
        m_pv[k]   = va && vb;
        m_prod[k] = sx(da, sg) * sx(db, sg);
      end
    end
    if (va) m_nda = da;
    if (vb) m_ndb = db;
    m_nva = va;
    m_nvb = vb;
  endtask

  task automatic check_all();
    for (int k = 0; k < 2; k++) begin
      logic [63:0] d, mask;
      d    = (k == 0) ? 64'(od40) : 64'(od32);
      mask = (k == 0) ? 64'hFF_FFFF_FFFF : 64'hFFFF_FFFF;
      chk($sformatf("out_valid[%0d]", k), 64'(ovld[k]), 64'(m_ovld[k]));
      chk($sformatf("out_data[%0d]", k), d, 64'(m_od[k]) & mask);
      chk($sformatf("out_sat[%0d]", k), 64'(osat[k]), 64'(m_osat[k]));
      chk($sformatf("busy[%0d]", k), 64'(busy[k]), 64'((m_cnt[k] != 0) || m_pv[k]));
      chk($sformatf("overrun[%0d]", k), 64'(ovr[k]), 64'(m_ov[k]));
      chk($sformatf("next_a[%0d]", k), {nda[k], 3'b0, nva[k]}, {m_nda, 3'b0, m_nva});
      chk($sformatf("next_b[%0d]", k), {ndb[k], 3'b0, nvb[k]}, {m_ndb, 3'b0, m_nvb});
    end
  endtask

  task automatic tick();
    if (!rstn) model_reset();
    else model_step();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic cyc(input logic [15:0] a, input logic [15:0] b, input logic v_a, input logic v_b);
    da = a; db = b; va = v_a; vb = v_b;
    tick();
  endtask

  function automatic logic [15:0] pick();
    case ($urandom_range(0, 5))
      0:       return 16'h7FFF;
      1:       return 16'h8000;
      2:       return 16'hFFFF;
      default: return 16'($urandom);
    endcase
  endfunction

  initial begin
    model_reset();
    tick(); tick();
    chk("rst_data", 64'(od40), 64'd0);
    rstn = 1'b1;
    out_ready = 1'b1;

    // Unsigned 3-product batch
    cfg_len = 8'd3; cfg_signed = 1'b0;
    cyc(2, 3, 1, 1); cyc(4, 5, 1, 1); cyc(6, 7, 1, 1);
    chk("s1_early", 64'(ovld[0]), 64'd0);
    cyc(0, 0, 0, 0);
    chk("s1_valid", 64'(ovld[0]), 64'd1);
    chk("s1_data", 64'(od40), 64'd68);
    chk("s1_sat", 64'(osat[0]), 64'd0);
    chk("s1_nda", 64'(nda[0]), 64'd6);
    cyc(0, 0, 0, 0);
    chk("s1_pulse", 64'(ovld[0]), 64'd0);

    // Signed vs unsigned interpretation of the same bits
    cfg_len = 8'd2; cfg_signed = 1'b1;
    cyc(16'hFFFF, 3, 1, 1); cyc(16'hFFFE, 16'hFFFE, 1, 1); cyc(0, 0, 0, 0);
    chk("s2_signed", 64'(od40), 64'd1);
    cyc(0, 0, 0, 0);
    cfg_signed = 1'b0;
    cyc(16'hFFFF, 3, 1, 1); cyc(16'hFFFE, 16'hFFFE, 1, 1); cyc(0, 0, 0, 0);
    chk("s2_unsigned", 64'(od40), 64'd196605 + 64'd65534 * 64'd65534);
    cyc(0, 0, 0, 0);
    cyc(16'hFFFF, 3, 1, 1); cyc(2, 2, 1, 1); cyc(0, 0, 0, 0);
    chk("s2_unsigned_small", 64'(od40), 64'd196609);
    cyc(0, 0, 0, 0);

    // Back-to-back single-product batches
    cfg_len = 8'd1;
    cyc(1, 1, 1, 1); cyc(2, 2, 1, 1);
    chk("s3_r1", 64'(od40), 64'd1);
    cyc(3, 3, 1, 1);
    chk("s3_r2", 64'(od40), 64'd4);
    cyc(4, 4, 1, 1);
    chk("s3_r3", 64'(od40), 64'd9);
    cyc(5, 0, 1, 0);
    chk("s3_r4", 64'(od40), 64'd16);
    chk("s3_r4_valid", 64'(ovld[0]), 64'd1);
    cyc(0, 0, 0, 0);
    chk("s3_no_prod", 64'(ovld[0]), 64'd0);
    chk("s3_fwd_a_only", 64'(nda[0]), 64'd5);

    // Backpressure and overrun
    out_ready = 1'b0;
    cyc(5, 5, 1, 1); cyc(6, 6, 1, 1); cyc(0, 0, 0, 0); cyc(0, 0, 0, 0);
    chk("s4_hold", 64'(od40), 64'd25);
    chk("s4_overrun", 64'(ovr[0]), 64'd1);
    out_ready = 1'b1;
    cyc(0, 0, 0, 0);
    chk("s4_accept", 64'(ovld[0]), 64'd0);
    clr = 1'b1;
    cyc(0, 0, 0, 0);
    clr = 1'b0;
    chk("s4_clr_ovr", 64'(ovr[0]), 64'd0);

    // Saturation on the 32-bit instance
    cfg_len = 8'd4; cfg_signed = 1'b1;
    repeat (4) cyc(16'h7FFF, 16'h7FFF, 1, 1);
    cyc(0, 0, 0, 0);
    chk("s5_pos_data", 64'(od32), 64'h7FFF_FFFF);
    chk("s5_pos_sat", 64'(osat[1]), 64'd1);
    chk("s5_wide_nosat", 64'(od40), 64'hFFFC_0004);
    cyc(0, 0, 0, 0);
    cfg_len = 8'd1;
    cyc(1, 1, 1, 1); cyc(0, 0, 0, 0); cyc(0, 0, 0, 0);
    chk("s5_next_sat", 64'(osat[1]), 64'd0);
    chk("s5_next_data", 64'(od32), 64'd1);
    cfg_len = 8'd3;
    repeat (3) cyc(16'h8000, 16'h7FFF, 1, 1);
    cyc(0, 0, 0, 0);
    chk("s5_neg_data", 64'(od32), 64'h8000_0000);
    chk("s5_neg_sat", 64'(osat[1]), 64'd1);
    cyc(0, 0, 0, 0);
    cfg_len = 8'd2; cfg_signed = 1'b0;
    repeat (2) cyc(16'hFFFF, 16'hFFFF, 1, 1);
    cyc(0, 0, 0, 0);
    chk("s5_uns_data", 64'(od32), 64'hFFFF_FFFF);
    chk("s5_uns_sat", 64'(osat[1]), 64'd1);
    cyc(0, 0, 0, 0);

    // Config frozen mid-batch
    cfg_len = 8'd3;
    cyc(1, 1, 1, 1);
    cfg_len = 8'd1;
    cyc(1, 1, 1, 1); cyc(1, 1, 1, 1);
    chk("s6_frozen", 64'(ovld[0]), 64'd0);
    cyc(0, 0, 0, 0);
    chk("s6_len3", 64'(od40), 64'd3);
    cyc(0, 0, 0, 0);

    // Flush mid-batch
    cfg_len = 8'd3;
    cyc(2, 2, 1, 1); cyc(2, 2, 1, 1);
    clr = 1'b1;
    cyc(0, 0, 0, 0);
    clr = 1'b0;
    chk("s6_clr_busy", 64'(busy[0]), 64'd0);
    cyc(0, 0, 0, 0); cyc(0, 0, 0, 0);
    chk("s6_clr_noout", 64'(ovld[0]), 64'd0);

    // Reset mid-batch
    cyc(3, 3, 1, 1); cyc(3, 3, 1, 1);
    rstn = 1'b0;
    #2;
    model_reset();
    check_all();
    chk("s6_rst_nda", 64'(nda[0]), 64'd0);
    tick();
    rstn = 1'b1;
    cyc(0, 0, 0, 0); cyc(0, 0, 0, 0);
    chk("s6_rst_noout", 64'(ovld[0]), 64'd0);

    // Randomized traffic
    for (int i = 0; i < 2000; i++) begin
      va = ($urandom_range(0, 9) < 7);
      vb = ($urandom_range(0, 9) < 7);
      da = pick();
      db = pick();
      if ($urandom_range(0, 7) == 0) cfg_len = 8'($urandom_range(0, 4));
      if ($urandom_range(0, 7) == 0) cfg_signed = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 9) < 7);
      clr = ($urandom_range(0, 49) == 0);
      tick();
    end
    clr = 1'b0;
    cyc(0, 0, 0, 0); cyc(0, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
